// File: rtl/brisc_pkg.sv
// Shared types for the brisc pipeline: result-source encoding and the
// writeback candidate record presented by each completion channel.
package brisc_pkg;

  typedef enum logic [1:0] {
    FROM_ALU     = 2'b00,
    FROM_CACHE   = 2'b01,
    FROM_PC_NEXT = 2'b10
  } result_src_e;

  localparam int WB_MAX_CH   = 4;
  localparam int WB_XLEN     = 32;
  localparam int WB_REG_BITS = 5;

  typedef struct packed {
    logic [WB_XLEN-1:0]     result;
    logic [WB_REG_BITS-1:0] rd;
    logic                   reg_write;
  } wb_cand_t;

endpackage

// File: rtl/wb_rr_arbiter.sv
// One-hot grant among NUM_CH requesters. WB_RR_ARB_EN selects round-robin
// (pointer = last granted, moves only on advance); otherwise lowest index wins.
module wb_rr_arbiter #(
  parameter int NUM_CH = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NUM_CH-1:0] req,
  input  logic              advance,
  output logic [NUM_CH-1:0] grant
);

`ifdef WB_RR_ARB_EN
  localparam int PTR_W = $clog2(NUM_CH);
  localparam logic [PTR_W-1:0] PTR_RST = PTR_W'(NUM_CH - 1);

  logic [PTR_W-1:0]  ptr;
  logic [PTR_W-1:0]  grant_idx;
  logic [NUM_CH-1:0] upper_req;
  logic [NUM_CH-1:0] pick_from;

  // Requests strictly above the pointer go first; wrap to the full set otherwise.
  always_comb begin
    upper_req = req & (({NUM_CH{1'b1}} << ptr) << 1);
    pick_from = (upper_req != '0) ? upper_req : req;
    grant     = pick_from & (~pick_from + NUM_CH'(1));
  end

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant[i]) grant_idx = PTR_W'(i);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr <= PTR_RST;
    end else if (advance) begin
      ptr <= grant_idx;
    end
  end
`else
  logic unused_ok;

  assign grant     = req & (~req + NUM_CH'(1));
  assign unused_ok = ^{clk, reset_n, advance};
`endif

endmodule

// File: rtl/wb_merge_stage.sv
// Writeback merge: selects each channel's result, arbitrates one winner and
// registers it toward the register file. Arbitration policy: WB_RR_ARB_EN.
module wb_merge_stage
  import brisc_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int REG_BITS = 5,
  parameter int NUM_CH   = 2
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic                                  stall_in,
  input  logic [NUM_CH-1:0]                     ch_valid_in,
  output logic [NUM_CH-1:0]                     ch_ready_out,
  input  logic [NUM_CH*XLEN-1:0]                ch_alu_res_in,
  input  logic [NUM_CH*XLEN-1:0]                ch_read_data_in,
  input  logic [NUM_CH*XLEN-1:0]                ch_pc_plus4_in,
  input  logic [NUM_CH*REG_BITS-1:0]            ch_rd_in,
  input  logic [NUM_CH-1:0]                     ch_reg_write_in,
  input  logic [NUM_CH*$bits(result_src_e)-1:0] ch_result_src_in,
  output logic                                  wb_valid_out,
  output logic [$clog2(NUM_CH)-1:0]             wb_ch_out,
  output logic                                  reg_write_out,
  output logic [REG_BITS-1:0]                   rd_out,
  output logic [XLEN-1:0]                       result_out
);

  localparam int SRC_W = $bits(result_src_e);
  localparam int CH_W  = $clog2(NUM_CH);

  wb_cand_t          cand [NUM_CH];
  wb_cand_t          win;
  logic [CH_W-1:0]   win_idx;
  logic [NUM_CH-1:0] req;
  logic [NUM_CH-1:0] grant;
  logic              handshake;

  // Unknown source encodings collapse to zero so X never reaches the regfile.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      cand[i].rd        = ch_rd_in[i*REG_BITS +: REG_BITS];
      cand[i].reg_write = ch_reg_write_in[i];
      case (ch_result_src_in[i*SRC_W +: SRC_W])
        FROM_ALU:     cand[i].result = ch_alu_res_in[i*XLEN +: XLEN];
        FROM_CACHE:   cand[i].result = ch_read_data_in[i*XLEN +: XLEN];
        FROM_PC_NEXT: cand[i].result = ch_pc_plus4_in[i*XLEN +: XLEN];
        default:      cand[i].result = '0;
      endcase
    end
  end

  assign req = ch_valid_in & {NUM_CH{~stall_in}};

  wb_rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req),
    .advance (handshake),
    .grant   (grant)
  );

  // Ready is forced low during reset even though grant is purely combinational.
  assign ch_ready_out = grant & {NUM_CH{~stall_in & reset_n}};
  assign handshake    = |ch_ready_out;

  always_comb begin
    win     = '0;
    win_idx = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant[i]) begin
        win     = cand[i];
        win_idx = CH_W'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wb_valid_out  <= 1'b0;
      wb_ch_out     <= '0;
      reg_write_out <= 1'b0;
      rd_out        <= '0;
      result_out    <= '0;
    end else if (!stall_in) begin
      if (handshake) begin
        wb_valid_out  <= 1'b1;
        wb_ch_out     <= win_idx;
        reg_write_out <= win.reg_write & (win.rd != '0);
        rd_out        <= win.rd;
        result_out    <= win.result;
      end else begin
        wb_valid_out  <= 1'b0;
        reg_write_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wb_merge_stage.sv
// Self-checking bench for wb_merge_stage (NUM_CH=3), valid with or without WB_RR_ARB_EN.
module tb_wb_merge_stage;
  localparam int N = 3;

  logic clk, reset_n, stall;
  logic [N-1:0]   valid;
  logic [31:0]    alu [N], rdat [N], pc4 [N];
  logic [4:0]     rd [N];
  logic           rw [N];
  logic [1:0]     src [N];

  logic [N*32-1:0] alu_bus, rdat_bus, pc4_bus;
  logic [N*5-1:0]  rd_bus;
  logic [N-1:0]    rw_bus;
  logic [N*2-1:0]  src_bus;
  logic [N-1:0]    ready;
  logic            wb_valid, wb_rw;
  logic [1:0]      wb_ch;
  logic [4:0]      wb_rd;
  logic [31:0]     wb_res;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      alu_bus[i*32 +: 32]  = alu[i];
      rdat_bus[i*32 +: 32] = rdat[i];
      pc4_bus[i*32 +: 32]  = pc4[i];
      rd_bus[i*5 +: 5]     = rd[i];
      rw_bus[i]            = rw[i];
      src_bus[i*2 +: 2]    = src[i];
    end
  end

  wb_merge_stage #(.XLEN(32), .REG_BITS(5), .NUM_CH(N)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .stall_in         (stall),
    .ch_valid_in      (valid),
    .ch_ready_out     (ready),
    .ch_alu_res_in    (alu_bus),
    .ch_read_data_in  (rdat_bus),
    .ch_pc_plus4_in   (pc4_bus),
    .ch_rd_in         (rd_bus),
    .ch_reg_write_in  (rw_bus),
    .ch_result_src_in (src_bus),
    .wb_valid_out     (wb_valid),
    .wb_ch_out        (wb_ch),
    .reg_write_out    (wb_rw),
    .rd_out           (wb_rd),
    .result_out       (wb_res)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state: registered outputs plus last-granted channel.
  logic        m_valid, m_rw;
  logic [1:0]  m_ch;
  logic [4:0]  m_rd;
  logic [31:0] m_res;
  int          m_last;
  int          last_g;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] sel_result(input int c);
    case (src[c])
      2'd0:    return alu[c];
      2'd1:    return rdat[c];
      2'd2:    return pc4[c];
      default: return 32'h0;
    endcase
  endfunction

  function automatic int model_grant();
    if (stall || !reset_n) return -1;
`ifdef WB_RR_ARB_EN
    for (int k = 1; k <= N; k++) begin
      if (valid[(m_last + k) % N]) return (m_last + k) % N;
    end
`else
    for (int i = 0; i < N; i++) begin
      if (valid[i]) return i;
    end
`endif
    return -1;
  endfunction

  task automatic cycle();
    int g;
    logic [N-1:0] er;
    #1;
    g  = model_grant();
    er = (g >= 0) ? N'(1 << g) : '0;
    check("ready", ready, er);
    @(posedge clk);
    if (!stall) begin
      if (g >= 0) begin
        m_valid = 1'b1;
        m_rw    = rw[g] && (rd[g] != 5'd0);
        m_rd    = rd[g];
        m_res   = sel_result(g);
        m_ch    = 2'(g);
        m_last  = g;
      end else begin
        m_valid = 1'b0;
        m_rw    = 1'b0;
      end
    end
    last_g = g;
    #1;
    check("wb_valid", wb_valid, m_valid);
    check("reg_write", wb_rw, m_rw);
    check("rd", wb_rd, m_rd);
    check("result", wb_res, m_res);
    check("wb_ch", wb_ch, m_ch);
  endtask

  task automatic model_reset();
    m_valid = 0; m_rw = 0; m_ch = 0; m_rd = 0; m_res = 0;
    m_last  = N - 1;
  endtask

  task automatic do_reset();
    #3 reset_n = 1'b0;
    #1;
    model_reset();
    check("rst_ready", ready, '0);
    check("rst_valid", wb_valid, 0);
    check("rst_rw", wb_rw, 0);
    check("rst_rd", wb_rd, 0);
    check("rst_result", wb_res, 0);
    check("rst_ch", wb_ch, 0);
    @(negedge clk);
    #2 reset_n = 1'b1;
  endtask

  task automatic rand_payload(input int c);
    alu[c]  = $urandom;
    rdat[c] = $urandom;
    pc4[c]  = $urandom;
    rd[c]   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
    rw[c]   = 1'($urandom);
    src[c]  = 2'($urandom_range(0, 3));
  endtask

  typedef struct {
    logic [1:0]  src;
    logic [31:0] alu, rdat, pc4;
    logic [4:0]  rd;
    logic        rw;
    logic [31:0] exp_res;
    logic        exp_rw;
  } vec_t;

  vec_t tbl [6];

  initial begin
    tbl[0] = '{2'd1, 32'h1111, 32'hDEADBEEF, 32'h44,  5'd5,  1'b1, 32'hDEADBEEF, 1'b1};
    tbl[1] = '{2'd0, 32'h12345678, 32'h2, 32'h3,      5'd31, 1'b1, 32'h12345678, 1'b1};
    tbl[2] = '{2'd2, 32'h5, 32'h6, 32'h104,           5'd0,  1'b1, 32'h104,      1'b0};
    tbl[3] = '{2'd2, 32'h5, 32'h6, 32'h108,           5'd7,  1'b0, 32'h108,      1'b0};
    tbl[4] = '{2'd0, 32'hCAFEF00D, 32'h0, 32'h0,      5'd3,  1'b0, 32'hCAFEF00D, 1'b0};
    tbl[5] = '{2'd3, 32'hAAAA, 32'hBBBB, 32'hCCCC,    5'd9,  1'b1, 32'h0,        1'b1};

    reset_n = 1'b0;
    stall   = 1'b0;
    valid   = 3'b010;
    last_g  = -1;
    for (int i = 0; i < N; i++) rand_payload(i);
    model_reset();
    #2;
    check("init_ready", ready, '0);
    check("init_valid", wb_valid, 0);
    check("init_result", wb_res, 0);
    @(negedge clk);
    #2 reset_n = 1'b1;

    // Table: single transactions on channel 0
    for (int t = 0; t < 6; t++) begin
      valid   = 3'b001;
      src[0]  = tbl[t].src;  alu[0] = tbl[t].alu; rdat[0] = tbl[t].rdat;
      pc4[0]  = tbl[t].pc4;  rd[0]  = tbl[t].rd;  rw[0]   = tbl[t].rw;
      cycle();
      check("tbl_valid", wb_valid, 1);
      check("tbl_ch", wb_ch, 0);
      check("tbl_rd", wb_rd, tbl[t].rd);
      check("tbl_result", wb_res, tbl[t].exp_res);
      check("tbl_rw", wb_rw, tbl[t].exp_rw);
    end
    valid = '0;
    cycle();
    check("idle_valid", wb_valid, 0);
    check("idle_result_hold", wb_res, 0);

    // Contention from a fresh pointer
    do_reset();
    valid = 3'b111;
    for (int k = 0; k < 6; k++) begin
      cycle();
`ifdef WB_RR_ARB_EN
      check("cont_order", wb_ch, k % 3);
`else
      check("cont_order", wb_ch, 0);
`endif
      if (last_g >= 0) alu[last_g] = $urandom;
    end

    // Stall with channel 1 waiting
    valid   = 3'b010;
    src[1]  = 2'd1; rdat[1] = 32'h5555AAAA; rd[1] = 5'd12; rw[1] = 1'b1;
    stall   = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      check("stall_ready", ready, '0);
    end
    stall = 1'b0;
    cycle();
    check("stall_retire_ch", wb_ch, 1);
    check("stall_retire_res", wb_res, 32'h5555AAAA);
    check("stall_retire_valid", wb_valid, 1);

    // Randomized traffic
    valid = '0;
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!valid[i] || last_g == i) begin
          valid[i] = ($urandom_range(0, 99) < 60);
          rand_payload(i);
        end
      end
      stall = ($urandom_range(0, 99) < 20);
      cycle();
    end

    // Mid-stream reset with channel 1 valid, then channel 0 wins first
    stall = 1'b0;
    valid = 3'b010;
    cycle();
    stall = 1'b1;
    cycle();
    do_reset();
    stall = 1'b0;
    valid = 3'b011;
    cycle();
    check("post_rst_ch", wb_ch, 0);
    check("post_rst_valid", wb_valid, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
